// File: rtl/prog_loader.sv
// Program loader for the SIC-4 core: streams bytes into instruction memory,
// verifies an 8-bit additive checksum, then releases the CPU.
module prog_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       imem_we,
  output logic [7:0] imem_addr,
  output logic [7:0] imem_wdata,
  output logic       cpu_run,
  output logic       busy,
  output logic       error,
  output logic [7:0] byte_count
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERR} state_t;

  state_t     state;
  logic [7:0] addr;
  logic [7:0] sum;
  logic       xfer;

  // busy is exactly the "LOAD or CHECK" condition, so it doubles as ready.
  assign in_ready   = busy;
  assign xfer       = in_valid & in_ready;
  assign imem_we    = xfer & (state == LOAD);
  assign imem_addr  = addr;
  assign imem_wdata = in_data;
  // The write address and the byte count advance in lockstep and wrap together.
  assign byte_count = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      sum     <= '0;
      busy    <= 1'b0;
      error   <= 1'b0;
      cpu_run <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN, ERR: begin
          if (start) begin
            state   <= LOAD;
            addr    <= '0;
            sum     <= '0;
            busy    <= 1'b1;
            error   <= 1'b0;
            cpu_run <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer) begin
            addr <= addr + 8'd1;
            sum  <= sum + in_data;
            if (in_last) begin
              state <= CHECK;
            end else if (addr == 8'hFF) begin
              state <= ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (xfer) begin
            busy <= 1'b0;
            if (in_data == sum) begin
              state   <= RUN;
              cpu_run <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          error   <= 1'b0;
          cpu_run <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; inputs change on the falling
// edge, a write monitor on the rising edge models instruction memory.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       cpu_run;
  logic       busy;
  logic       error;
  logic [7:0] byte_count;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  int unsigned wr_cnt = 0;
  logic [7:0]  wr_addr[$];
  logic [7:0]  mem[256];

  always #5 clk = ~clk;

  prog_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .error      (error),
    .byte_count (byte_count)
  );

  always @(posedge clk) begin
    if (imem_we) begin
      wr_cnt++;
      wr_addr.push_back(imem_addr);
      mem[imem_addr] = imem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_cnt = 0;
    wr_addr.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One transfer with a stall cycle after it; checks the same-cycle write strobe.
  task automatic xfer(input string tag, input logic [7:0] d, input logic l, input logic exp_we);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #1;
    check({tag, "_ready"}, in_ready, 1'b1);
    check({tag, "_we"}, imem_we, exp_we);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int unsigned bad;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    #2;
    check("rst_ready", in_ready, 1'b0);
    check("rst_we", imem_we, 1'b0);
    check("rst_run", cpu_run, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_count", byte_count, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_autostart", busy, 1'b0);

    // Nominal load: 41+52+13 = A6
    clear_log();
    pulse_start();
    check("load_busy", busy, 1'b1);
    check("load_count0", byte_count, 8'd0);
    xfer("n0", 8'h41, 1'b0, 1'b1);
    xfer("n1", 8'h52, 1'b0, 1'b1);
    xfer("n2", 8'h13, 1'b1, 1'b1);
    check("nom_count", byte_count, 8'd3);
    check("nom_check_busy", busy, 1'b1);
    check("nom_run_before", cpu_run, 1'b0);
    xfer("nc", 8'hA6, 1'b0, 1'b0);
    check("nom_run", cpu_run, 1'b1);
    check("nom_ready_off", in_ready, 1'b0);
    check("nom_writes", wr_cnt, 3);
    check("nom_mem0", mem[0], 8'h41);
    check("nom_mem1", mem[1], 8'h52);
    check("nom_mem2", mem[2], 8'h13);
    check("nom_addr2", wr_addr.size() == 3 ? wr_addr[2] : 8'hEE, 8'd2);

    // Reload from RUN
    clear_log();
    pulse_start();
    check("reload_run_drop", cpu_run, 1'b0);
    check("reload_busy", busy, 1'b1);
    xfer("r0", 8'hC0, 1'b1, 1'b1);
    xfer("rc", 8'hC0, 1'b0, 1'b0);
    check("reload_run", cpu_run, 1'b1);
    check("reload_writes", wr_cnt, 1);
    check("reload_mem0", mem[0], 8'hC0);
    check("reload_count", byte_count, 8'd1);

    // Bad checksum
    clear_log();
    pulse_start();
    xfer("b0", 8'h41, 1'b0, 1'b1);
    xfer("b1", 8'h52, 1'b0, 1'b1);
    xfer("b2", 8'h13, 1'b1, 1'b1);
    xfer("bc", 8'hA5, 1'b0, 1'b0);
    check("bad_error", error, 1'b1);
    check("bad_run", cpu_run, 1'b0);
    check("bad_ready", in_ready, 1'b0);
    check("bad_writes", wr_cnt, 3);
    repeat (2) @(negedge clk);
    check("bad_err_holds", error, 1'b1);

    // Stall pattern 1,0,0,1 with start ignored mid-load
    clear_log();
    pulse_start();
    check("stall_err_cleared", error, 1'b0);
    @(negedge clk); in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk); in_valid = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("stall_hold_count", byte_count, 8'd1);
    @(negedge clk); in_valid = 1'b1; in_data = 8'h22;
    @(negedge clk); in_valid = 1'b0;
    check("stall_writes", wr_cnt, 2);
    check("stall_addr0", wr_addr.size() == 2 ? wr_addr[0] : 8'hEE, 8'd0);
    check("stall_addr1", wr_addr.size() == 2 ? wr_addr[1] : 8'hEE, 8'd1);
    check("stall_mem1", mem[1], 8'h22);
    check("stall_count", byte_count, 8'd2);

    // Overflow: 256 bytes, none last (start ignored in LOAD, so restart via reset)
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h01;
      in_last  = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("ovf_writes", wr_cnt, 256);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (i >= wr_addr.size() || wr_addr[i] != i[7:0]) bad++;
    check("ovf_addr_seq", bad, 0);
    check("ovf_error", error, 1'b1);
    check("ovf_count", byte_count, 8'd0);
    check("ovf_ready", in_ready, 1'b0);

    // Reset mid-load
    clear_log();
    pulse_start();
    xfer("m0", 8'hA1, 1'b0, 1'b1);
    xfer("m1", 8'hA2, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA3;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_we", imem_we, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_count", byte_count, 8'd0);
    check("mid_rst_error", error, 1'b0);
    check("mid_rst_run", cpu_run, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    check("mid_rst_nowrite", wr_cnt, 2);
    repeat (2) @(negedge clk);
    check("mid_rst_idle", busy, 1'b0);
    clear_log();
    pulse_start();
    xfer("p0", 8'h55, 1'b1, 1'b1);
    check("mid_rst_addr0", wr_addr.size() == 1 ? wr_addr[0] : 8'hEE, 8'd0);
    xfer("pc", 8'h55, 1'b0, 1'b0);
    check("mid_rst_run_after", cpu_run, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
